// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the program-counter controller.
//   state_e   : controller FSM states
//   pc_src_e  : which source was selected for the next PC
//   RESET_VECTOR_DEFAULT : default PC loaded on reset
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JAL  = 2'd2,
    SRC_JALR = 2'd3
  } pc_src_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_sel.sv
// pc_target_sel: combinational next-PC adders and priority select.
//   pc, imm, rs1          : operands (imm is already sign-extended)
//   br_en, br_taken       : conditional branch and its comparator outcome
//   jal, jalr             : jump flags; jalr has highest priority
//   next_pc               : selected target
//   pc_plus4              : sequential target / link value
//   src                   : which source produced next_pc
module pc_target_sel
  import pc_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        br_en,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output pc_src_e     src
);

  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  // All sums wrap modulo 2^32 by truncation to 32 bits.
  assign pc_plus4 = pc + 32'd4;
  assign pc_rel   = pc + imm;
  assign reg_rel  = rs1 + imm;

  always_comb begin
    src     = SRC_SEQ;
    next_pc = pc_plus4;
    if (jalr) begin
      src     = SRC_JALR;
      next_pc = {reg_rel[31:1], 1'b0};
    end else if (jal) begin
      src     = SRC_JAL;
      next_pc = pc_rel;
    end else if (br_en && br_taken) begin
      src     = SRC_BR;
      next_pc = pc_rel;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter controller with fetch handshake and misalignment trap.
//   clk, rst             : clock, asynchronous active-low reset
//   br_en/br_taken/jal/jalr/imm/rs1 : control flow of the current instruction
//   stall                : hold the PC and stop fetching
//   imem_gnt / imem_req / imem_addr : instruction fetch handshake
//   pc, pc_plus4         : current PC and its link value
//   redirect             : next PC is not pc+4 (FETCH only)
//   trap, trap_addr      : sticky misaligned-target flag and offending address
//   instret              : count of PC advances
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_BOOT  | one idle cycle after reset, no request
// ST_FETCH | requesting; advances PC on grant unless stalled
// ST_HOLD  | stalled, no request, PC held
// ST_TRAP  | misaligned target seen; frozen until reset
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_en,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  input  logic        imem_gnt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] next_pc;
  pc_src_e     src;

  pc_target_sel u_target_sel (
    .pc       (pc_q),
    .imm      (imm),
    .rs1      (rs1),
    .br_en    (br_en),
    .br_taken (br_taken),
    .jal      (jal),
    .jalr     (jalr),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4),
    .src      (src)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      instret_q   <= 32'd0;
      trap_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instret_q   <= instret_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instret_d   = instret_q;
    trap_addr_d = trap_addr_q;
    imem_req    = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        // stall wins over a grant in the same cycle
        if (stall) begin
          state_d = ST_HOLD;
        end else if (imem_gnt) begin
          if (next_pc[1]) begin
            state_d     = ST_TRAP;
            trap_addr_d = next_pc;
          end else begin
            pc_d      = next_pc;
            instret_d = instret_q + 32'd1;
          end
        end
      end
      ST_HOLD: begin
        if (!stall) state_d = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_BOOT;
    endcase
  end

  assign redirect  = (state_q == ST_FETCH) && (src != SRC_SEQ);
  assign trap      = (state_q == ST_TRAP);
  assign trap_addr = trap_addr_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_en, br_taken, jal, jalr, stall, imem_gnt;
  logic [31:0] imm, rs1;
  logic        imem_req, redirect, trap;
  logic [31:0] imem_addr, pc, pc_plus4, trap_addr, instret;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instret;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .br_en     (br_en),
    .br_taken  (br_taken),
    .jal       (jal),
    .jalr      (jalr),
    .imm       (imm),
    .rs1       (rs1),
    .stall     (stall),
    .imem_gnt  (imem_gnt),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .trap      (trap),
    .trap_addr (trap_addr),
    .instret   (instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic bre, input logic brt,
                                             input logic j, input logic jr,
                                             input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] t;
    if (jr) begin
      t = r1 + im;
      t[0] = 1'b0;
    end else if (j || (bre && brt)) t = p + im;
    else t = p + 32'd4;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic bre, input logic brt, input logic j, input logic jr,
                          input logic [31:0] im, input logic [31:0] r1,
                          input logic st, input logic g);
    br_en = bre; br_taken = brt; jal = j; jalr = jr;
    imm = im; rs1 = r1; stall = st; imem_gnt = g;
  endtask

  // Granted, unstalled advance: push expected PC, check redirect, then pop after the edge.
  task automatic adv(input string tag, input logic bre, input logic brt, input logic j,
                     input logic jr, input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] e;
    set_ctrl(bre, brt, j, jr, im, r1, 1'b0, 1'b1);
    e = model_next(model_pc, bre, brt, j, jr, im, r1);
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, "_redirect"}, {31'd0, redirect}, {31'd0, (jr | j | (bre & brt))});
    chk({tag, "_addr"}, imem_addr, model_pc);
    tick();
    model_pc = sb_q.pop_front();
    model_instret = model_instret + 32'd1;
    chk({tag, "_pc"}, pc, model_pc);
    chk({tag, "_instret"}, instret, model_instret);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    model_pc = 32'h0;
    model_instret = 32'h0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_trap_addr", trap_addr, 32'd0);
    rst = 1'b1;
    #1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    do_reset();

    // three sequential fetches: 0 -> 4 -> 8 -> 12
    adv("seq1", 0, 0, 0, 0, 32'd0, 32'd0);
    adv("seq2", 0, 0, 0, 0, 32'd0, 32'd0);
    adv("seq3", 0, 0, 0, 0, 32'd0, 32'd0);
    chk("seq_pc12", pc, 32'd12);

    adv("jal_to_100", 0, 0, 1, 0, 32'h0000_00F4, 32'd0);
    chk("pc_100", pc, 32'h100);
    adv("br_back", 1, 1, 0, 0, 32'hFFFF_FFF8, 32'd0);
    chk("pc_F8", pc, 32'hF8);
    adv("jal_jalr", 0, 0, 1, 1, 32'd1, 32'h203);
    chk("pc_204", pc, 32'h204);
    adv("br_not_taken", 1, 0, 0, 0, 32'h40, 32'd0);

    // no grant: controls ignored, request held
    set_ctrl(0, 0, 1, 0, 32'h1000, 32'd0, 1'b0, 1'b0);
    tick();
    chk("nognt_pc", pc, model_pc);
    chk("nognt_req", {31'd0, imem_req}, 32'd1);
    chk("nognt_instret", instret, model_instret);

    // stall handling at 0x40
    adv("jalr_40", 0, 0, 0, 1, 32'd0, 32'h40);
    set_ctrl(0, 0, 1, 0, 32'h80, 32'd0, 1'b1, 1'b1);
    tick();
    chk("hold1_pc", pc, 32'h40);
    chk("hold1_req", {31'd0, imem_req}, 32'd0);
    chk("hold1_redirect", {31'd0, redirect}, 32'd0);
    tick();
    chk("hold2_pc", pc, 32'h40);
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    set_ctrl(0, 0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("unhold_req", {31'd0, imem_req}, 32'd1);
    chk("unhold_pc", pc, 32'h40);
    adv("after_stall", 0, 0, 0, 0, 32'd0, 32'd0);
    chk("pc_44", pc, 32'h44);

    // wrap at top of address space
    adv("jalr_top", 0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC);
    adv("wrap", 0, 0, 0, 0, 32'd0, 32'd0);
    chk("wrap_pc0", pc, 32'h0);

    // asynchronous reset mid-request at 0xFFFF_FFFC
    adv("jalr_top2", 0, 0, 0, 1, 32'd0, 32'hFFFF_FFFC);
    set_ctrl(0, 0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_instret", instret, 32'd0);
    do_reset();

    // misaligned JALR target -> sticky trap
    set_ctrl(0, 0, 0, 1, 32'd0, 32'h102, 1'b0, 1'b1);
    tick();
    chk("trap_flag", {31'd0, trap}, 32'd1);
    chk("trap_addr", trap_addr, 32'h102);
    chk("trap_pc", pc, 32'h0);
    chk("trap_req", {31'd0, imem_req}, 32'd0);
    chk("trap_instret", instret, 32'd0);
    set_ctrl(0, 0, 0, 0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
    chk("trap_sticky", {31'd0, trap}, 32'd1);
    chk("trap_pc_held", pc, 32'h0);
    chk("trap_redirect", {31'd0, redirect}, 32'd0);
    do_reset();
    adv("post_trap", 0, 0, 0, 0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
